// File: rtl/verificador_sumador_pkg.sv
// Shared types and constants for the adder result checker.
package verificador_sumador_pkg;

   localparam int unsigned REC_W = 8;
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

   typedef logic [REC_W-1:0] rec_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      TOUT = 2'd2
   } state_t;

endpackage

// File: rtl/verificador_sumador_fifo_esperado.sv
// Show-ahead FIFO of expected {idx, sum} records awaiting an adder response.
module fifo_esperado
   import verificador_sumador_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic push,
   input  logic pop,
   input  rec_t din,
   output rec_t dout,
   output logic full,
   output logic empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   rec_t        mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is accepted only when the head leaves at the same edge.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/verificador_sumador.sv
// In-order checker of the pipelined 4-bit adder: expected-sum queue, counters, flags, watchdog.
module verificador_sumador
   import verificador_sumador_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [3:0]       dataA,
   input  logic [3:0]       dataB,
   input  logic [3:0]       idx,
   input  logic             rsp_valid,
   input  logic [3:0]       sum30_dd_out,
   input  logic [3:0]       idx_dd_out,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             mismatch,
   output logic             overflow,
   output logic             unexpected,
   output logic             timeout,
   output logic             busy
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

   state_t          state_q, state_d;
   logic [WD_W-1:0] wd_q, wd_d;
   rec_t            head;
   logic            full, empty;
   logic            pop_ok, push_ok, head_ok, fail;
   logic [3:0]      exp_sum;

   assign exp_sum = dataA + dataB;
   assign pop_ok  = rsp_valid & ~empty;
   assign push_ok = in_valid & (~full | pop_ok);
   assign head_ok = (head == {idx_dd_out, sum30_dd_out});
   assign fail    = rsp_valid & (empty | ~head_ok);

   fifo_esperado #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .push  (push_ok),
      .pop   (pop_ok),
      .din   ({idx, exp_sum}),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // State lags FIFO emptiness by one cycle on the way back to IDLE; the watchdog
   // is held at zero whenever the FIFO is empty, so that lag is never observable.
   always_comb begin
      state_d = state_q;
      wd_d    = '0;
      case (state_q)
         IDLE: if (push_ok) state_d = WAIT;
         WAIT: begin
            if (empty && !push_ok) begin
               state_d = IDLE;
            end else if (!rsp_valid && !empty) begin
               wd_d = wd_q + 1'b1;
               if (wd_d == WD_W'(TIMEOUT)) state_d = TOUT;
            end
         end
         TOUT: state_d = TOUT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wd_q       <= '0;
         pass_cnt   <= '0;
         err_cnt    <= '0;
         mismatch   <= 1'b0;
         overflow   <= 1'b0;
         unexpected <= 1'b0;
      end else if (clr) begin
         state_q    <= IDLE;
         wd_q       <= '0;
         pass_cnt   <= '0;
         err_cnt    <= '0;
         mismatch   <= 1'b0;
         overflow   <= 1'b0;
         unexpected <= 1'b0;
      end else begin
         state_q  <= state_d;
         wd_q     <= wd_d;
         mismatch <= fail;
         if (pop_ok && head_ok && pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
         if (fail && err_cnt != CNT_MAX)               err_cnt  <= err_cnt + 1'b1;
         if (in_valid && full && !pop_ok)              overflow <= 1'b1;
         if (rsp_valid && empty)                       unexpected <= 1'b1;
      end
   end

   assign timeout = (state_q == TOUT);
   assign busy    = ~empty;

endmodule

// File: tb/tb_verificador_sumador.sv
// Bench for verificador_sumador: directed scenarios plus randomized traffic against a queue model.
module tb_verificador_sumador;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   logic       clk = 1'b0;
   logic       reset, clr, in_valid, rsp_valid;
   logic [3:0] dataA, dataB, idx, sum30_dd_out, idx_dd_out;
   logic [7:0] pass_cnt, err_cnt;
   logic       mismatch, overflow, unexpected, timeout, busy;

   always #5 clk = ~clk;

   verificador_sumador #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .clr          (clr),
      .in_valid     (in_valid),
      .dataA        (dataA),
      .dataB        (dataB),
      .idx          (idx),
      .rsp_valid    (rsp_valid),
      .sum30_dd_out (sum30_dd_out),
      .idx_dd_out   (idx_dd_out),
      .pass_cnt     (pass_cnt),
      .err_cnt      (err_cnt),
      .mismatch     (mismatch),
      .overflow     (overflow),
      .unexpected   (unexpected),
      .timeout      (timeout),
      .busy         (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model: queue of outstanding expectations plus counters and flags
   logic [7:0] q[$];
   int         m_pass, m_err, m_wd;
   bit         m_mm, m_ovf, m_unx, m_tout;

   // emulated 2-stage adder used to generate responses
   bit         pv[2];
   logic [3:0] ps[2], pi[2];

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_clear();
      q.delete();
      m_pass = 0; m_err = 0; m_wd = 0;
      m_mm = 0; m_ovf = 0; m_unx = 0; m_tout = 0;
   endfunction

   function automatic void model_edge();
      int         size0;
      bit         was_empty, popped;
      logic [7:0] head;
      int         s;
      if (clr) begin
         model_clear();
         return;
      end
      size0     = q.size();
      was_empty = (size0 == 0);
      popped    = 0;
      m_mm      = 0;
      if (rsp_valid) begin
         if (was_empty) begin
            m_unx = 1;
            m_mm  = 1;
            if (m_err < 255) m_err++;
         end else begin
            head   = q.pop_front();
            popped = 1;
            if (head == {idx_dd_out, sum30_dd_out}) begin
               if (m_pass < 255) m_pass++;
            end else begin
               m_mm = 1;
               if (m_err < 255) m_err++;
            end
         end
      end
      if (in_valid) begin
         if (size0 == DEPTH && !popped) begin
            m_ovf = 1;
         end else begin
            s = (int'(dataA) + int'(dataB)) % 16;
            q.push_back({idx, 4'(s)});
         end
      end
      // watchdog: consecutive cycles with records outstanding and no response
      if (!m_tout) begin
         if (rsp_valid || was_empty) m_wd = 0;
         else begin
            m_wd++;
            if (m_wd >= TIMEOUT) m_tout = 1;
         end
      end
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".pass_cnt"},   pass_cnt,   m_pass);
      check({tag, ".err_cnt"},    err_cnt,    m_err);
      check({tag, ".mismatch"},   mismatch,   m_mm);
      check({tag, ".overflow"},   overflow,   m_ovf);
      check({tag, ".unexpected"}, unexpected, m_unx);
      check({tag, ".timeout"},    timeout,    m_tout);
      check({tag, ".busy"},       busy,       q.size() != 0);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_all("cyc");
   endtask

   task automatic drive(input bit iv, input int a, input int b, input int id,
                        input bit rv, input int s, input int ri);
      in_valid     = iv;
      dataA        = 4'(a);
      dataB        = 4'(b);
      idx          = 4'(id);
      rsp_valid    = rv;
      sum30_dd_out = 4'(s);
      idx_dd_out   = 4'(ri);
      cycle();
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      idle();
      clr = 1'b0;
      pv[0] = 0;
      pv[1] = 0;
   endtask

   task automatic async_reset();
      #2;
      reset = 1'b1;
      #1;
      model_clear();
      check_all("async_rst");
      #1;
      reset = 1'b0;
   endtask

   task automatic pipe_step(input bit iv, input int corrupt_pct, input int drop_pct);
      logic [3:0] a, b, id;
      a  = 4'($urandom);
      b  = 4'($urandom);
      id = 4'($urandom);
      in_valid     = iv;
      dataA        = a;
      dataB        = b;
      idx          = id;
      rsp_valid    = pv[1] && ($urandom_range(99) >= drop_pct);
      sum30_dd_out = ps[1];
      idx_dd_out   = pi[1];
      if ($urandom_range(99) < corrupt_pct)
         sum30_dd_out = ps[1] ^ 4'(1 + $urandom_range(14));
      pv[1] = pv[0]; ps[1] = ps[0]; pi[1] = pi[0];
      pv[0] = iv;    ps[0] = a + b; pi[0] = id;
      cycle();
   endtask

   initial begin
      reset = 1'b1; clr = 1'b0;
      in_valid = 0; dataA = 0; dataB = 0; idx = 0;
      rsp_valid = 0; sum30_dd_out = 0; idx_dd_out = 0;
      pv[0] = 0; pv[1] = 0;
      model_clear();
      #3;
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;

      // ordered traffic, responses two cycles after issue
      drive(1, 3, 4, 0, 0, 0, 0);
      drive(1, 9, 9, 1, 0, 0, 0);
      drive(1, 15, 1, 2, 1, 7, 0);
      drive(0, 0, 0, 0, 1, 2, 1);
      drive(0, 0, 0, 0, 1, 0, 2);
      idle();
      check("ord.pass", pass_cnt, 3);
      check("ord.err", err_cnt, 0);
      check("ord.busy", busy, 0);

      // corrupted sum, then wrong tag
      do_clr();
      drive(1, 5, 6, 4, 0, 0, 0);
      idle();
      drive(0, 0, 0, 0, 1, 10, 4);
      check("bad_sum.err", err_cnt, 1);
      check("bad_sum.mismatch", mismatch, 1);
      check("bad_sum.pass", pass_cnt, 0);
      idle();
      check("bad_sum.mismatch_low", mismatch, 0);
      drive(1, 1, 1, 5, 0, 0, 0);
      idle();
      drive(0, 0, 0, 0, 1, 2, 6);
      check("bad_idx.err", err_cnt, 2);

      // overflow then drain, then one response too many
      do_clr();
      for (int i = 0; i < 5; i++) begin
         drive(1, i, i + 1, i, 0, 0, 0);
         check("ovf.flag", overflow, i == 4);
      end
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, (2 * i + 1) % 16, i);
      check("ovf.pass", pass_cnt, 4);
      drive(0, 0, 0, 0, 1, 9, 4);
      check("ovf.unexpected", unexpected, 1);
      check("ovf.err", err_cnt, 1);

      // watchdog
      do_clr();
      drive(1, 2, 2, 3, 0, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         idle();
         check("tout.flag", timeout, i >= 8);
      end
      drive(0, 0, 0, 0, 1, 4, 3);
      check("tout.pass", pass_cnt, 1);
      check("tout.sticky", timeout, 1);

      // saturation
      do_clr();
      for (int k = 0; k < 302; k++) pipe_step(k < 300, 0, 0);
      check("sat.pass", pass_cnt, 255);
      check("sat.err", err_cnt, 0);

      // asynchronous reset with two records outstanding
      do_clr();
      drive(1, 2, 3, 7, 0, 0, 0);
      drive(1, 4, 4, 8, 0, 0, 0);
      async_reset();
      check("arst.busy", busy, 0);
      drive(0, 0, 0, 0, 1, 5, 7);
      drive(0, 0, 0, 0, 1, 8, 8);
      check("arst.unexpected", unexpected, 1);
      check("arst.err", err_cnt, 2);

      // same with synchronous clear
      do_clr();
      drive(1, 2, 3, 7, 0, 0, 0);
      drive(1, 4, 4, 8, 0, 0, 0);
      do_clr();
      check("clr.busy", busy, 0);
      drive(0, 0, 0, 0, 1, 5, 7);
      drive(0, 0, 0, 0, 1, 8, 8);
      check("clr.unexpected", unexpected, 1);
      check("clr.err", err_cnt, 2);

      // randomized traffic with corruption, drops and occasional clear
      do_clr();
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(99) == 0) do_clr();
         else pipe_step($urandom_range(2) != 0, 8, 4);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
